mesh_term_inj_arb: RTL and testbench

- Round-robin injection arbiter that shares one mesh_gnrtr terminal input between N_REQ local packet sources.
- Drives the router-side terminal pair (data_out_i_in, pndng_i_in) and consumes the router's popin handshake.
- Holds a single-entry output register.
- Screens out packets with out-of-range destinations, clears the Nxtjp field, and reports drops and protocol errors.

---
 rtl/mesh_term_inj_arb_if.sv | 30 +++
 rtl/mesh_term_inj_arb.sv | 115 +++++++++++
 tb/tb_mesh_term_inj_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_term_inj_arb_if.sv
// Bundle of the requester-side and router-terminal signals of the injection arbiter.
// The master modport is the environment (requesters + router); the slave modport is the arbiter.
interface mesh_term_inj_arb_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned pckg_sz = 40
);
  localparam int unsigned GntW = $clog2(N_REQ);

  logic                       en;
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*pckg_sz-1:0]   req_data;
  logic [N_REQ-1:0]           req_ready;
  logic [pckg_sz-1:0]         data_out_i_in;
  logic                       pndng_i_in;
  logic                       popin;
  logic [GntW-1:0]            gnt_id;
  logic [15:0]                drop_cnt;
  logic                       drop_pulse;
  logic                       err_pop;

  modport master (
    output en, req_valid, req_data, popin,
    input  req_ready, data_out_i_in, pndng_i_in, gnt_id, drop_cnt, drop_pulse, err_pop
  );

  modport slave (
    input  en, req_valid, req_data, popin,
    output req_ready, data_out_i_in, pndng_i_in, gnt_id, drop_cnt, drop_pulse, err_pop
  );
endinterface

// File: rtl/mesh_term_inj_arb.sv
// Round-robin arbiter sharing one mesh router terminal input among N_REQ packet sources,
// with a single-entry output register, destination screening and drop/error reporting.
module mesh_term_inj_arb #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ROWS    = 4,
  parameter int unsigned COLUMS  = 4,
  parameter int unsigned pckg_sz = 40
) (
  input logic                clk,
  input logic                reset,
  mesh_term_inj_arb_if.slave bus
);

  localparam int unsigned GntW   = $clog2(N_REQ);
  localparam logic [4:0]  RowMax = 5'(ROWS + 1);
  localparam logic [4:0]  ColMax = 5'(COLUMS + 1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e               state_q;
  logic [GntW-1:0]      rr_ptr_q;
  logic [pckg_sz-1:0]   data_q;
  logic [GntW-1:0]      gnt_q;
  logic [15:0]          drop_cnt_q;
  logic                 drop_pulse_q;
  logic                 err_pop_q;

  logic [GntW:0]        cand_sum;
  logic [GntW-1:0]      gnt_sel;
  logic [GntW-1:0]      rr_next;
  logic                 found;
  logic [pckg_sz-1:0]   pkt;
  logic [3:0]           pkt_row;
  logic [3:0]           pkt_col;
  logic                 legal;
  logic                 win_open;
  logic                 accept;
  logic [N_REQ-1:0]     ready;

  // Search rr_ptr, rr_ptr+1, ... (mod N_REQ) for the first valid requester.
  always_comb begin
    found    = 1'b0;
    gnt_sel  = '0;
    cand_sum = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (GntW+1)'(k);
      if (cand_sum >= (GntW+1)'(N_REQ)) cand_sum = cand_sum - (GntW+1)'(N_REQ);
      if (!found && bus.req_valid[cand_sum[GntW-1:0]]) begin
        found   = 1'b1;
        gnt_sel = cand_sum[GntW-1:0];
      end
    end
  end

  always_comb begin
    pkt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_sel == GntW'(i)) pkt = bus.req_data[i*pckg_sz +: pckg_sz];
    end
  end

  assign pkt_row  = pkt[pckg_sz-9 -: 4];
  assign pkt_col  = pkt[pckg_sz-13 -: 4];
  assign legal    = ({1'b0, pkt_row} <= RowMax) && ({1'b0, pkt_col} <= ColMax);
  // Reset gates the window so no requester sees an accept while reset is held.
  assign win_open = reset && bus.en && ((state_q == StEmpty) || bus.popin);
  assign accept   = win_open && found;
  assign rr_next  = (gnt_sel == GntW'(N_REQ - 1)) ? '0 : gnt_sel + GntW'(1);

  always_comb begin
    ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      ready[i] = accept && (gnt_sel == GntW'(i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StEmpty;
      rr_ptr_q     <= '0;
      data_q       <= '0;
      gnt_q        <= '0;
      drop_cnt_q   <= '0;
      drop_pulse_q <= 1'b0;
      err_pop_q    <= 1'b0;
    end else begin
      drop_pulse_q <= 1'b0;
      if (accept) rr_ptr_q <= rr_next;

      if (accept && legal) begin
        data_q  <= {8'h00, pkt[pckg_sz-9:0]};
        gnt_q   <= gnt_sel;
        state_q <= StFull;
      end else if ((state_q == StFull) && bus.popin) begin
        state_q <= StEmpty;
      end

      if (accept && !legal) begin
        drop_pulse_q <= 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end

      if ((state_q == StEmpty) && bus.popin) err_pop_q <= 1'b1;
    end
  end

  assign bus.req_ready     = ready;
  assign bus.data_out_i_in = data_q;
  assign bus.pndng_i_in    = (state_q == StFull);
  assign bus.gnt_id        = gnt_q;
  assign bus.drop_cnt      = drop_cnt_q;
  assign bus.drop_pulse    = drop_pulse_q;
  assign bus.err_pop       = err_pop_q;

endmodule

// File: tb/tb_mesh_term_inj_arb.sv
// Directed bench for mesh_term_inj_arb: expected pops and drops are queued as stimulus is issued,
// and a negedge monitor compares them whenever the DUT presents a pop or a drop pulse.
module tb_mesh_term_inj_arb;

  localparam int unsigned NReq = 4;
  localparam int unsigned PSz  = 40;

  typedef struct packed {
    logic [PSz-1:0] data;
    logic [1:0]     id;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  exp_t        exp_q[$];
  logic [15:0] drop_q[$];
  exp_t        mon_e;
  logic [15:0] mon_d;
  logic [NReq-1:0] acc;

  mesh_term_inj_arb_if #(.N_REQ(NReq), .pckg_sz(PSz)) bus ();

  mesh_term_inj_arb #(
    .N_REQ  (NReq),
    .ROWS   (4),
    .COLUMS (4),
    .pckg_sz(PSz)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [PSz-1:0] mk(input logic [7:0] nx, input logic [3:0] r,
                                        input logic [3:0] c, input logic m,
                                        input logic [22:0] p);
    return {nx, r, c, m, p};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; requesters whose ready bit was seen drop their valid.
  task automatic tick();
    @(posedge clk);
    acc = bus.req_ready;
    #1;
    bus.req_valid = bus.req_valid & ~acc;
  endtask

  task automatic set_req(input int i, input logic [PSz-1:0] p);
    bus.req_data[i*PSz +: PSz] = p;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic push_exp(input logic [PSz-1:0] d, input logic [1:0] id);
    exp_t e;
    e.data = d;
    e.id   = id;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.pndng_i_in && bus.popin) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected: got %0h expected none", bus.data_out_i_in);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pop_data", 64'(bus.data_out_i_in), 64'(mon_e.data));
          chk("pop_gnt", 64'(bus.gnt_id), 64'(mon_e.id));
        end
      end
      if (bus.drop_pulse) begin
        if (drop_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL drop_unexpected: got cnt %0d expected no drop", bus.drop_cnt);
        end else begin
          mon_d = drop_q.pop_front();
          chk("drop_cnt_mon", 64'(bus.drop_cnt), 64'(mon_d));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] order [4];
    logic [PSz-1:0] held;
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    bus.en        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.popin     = 1'b0;

    // Reset state, with requests present and en high.
    #2;
    bus.req_valid = 4'b1111;
    bus.en        = 1'b1;
    #1;
    chk("rst_ready", 64'(bus.req_ready), 64'h0);
    chk("rst_pndng", 64'(bus.pndng_i_in), 64'h0);
    chk("rst_data", 64'(bus.data_out_i_in), 64'h0);
    chk("rst_gnt", 64'(bus.gnt_id), 64'h0);
    chk("rst_drop_cnt", 64'(bus.drop_cnt), 64'h0);
    chk("rst_drop_pulse", 64'(bus.drop_pulse), 64'h0);
    chk("rst_err_pop", 64'(bus.err_pop), 64'h0);
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single packet: Nxtjp cleared, one-cycle latency, pop empties.
    set_req(0, mk(8'hAA, 4'd0, 4'd2, 1'b1, 23'd1));
    #1 chk("t1_ready", 64'(bus.req_ready), 64'h1);
    push_exp(mk(8'h00, 4'd0, 4'd2, 1'b1, 23'd1), 2'd0);
    tick();
    chk("t1_pndng", 64'(bus.pndng_i_in), 64'h1);
    chk("t1_gnt", 64'(bus.gnt_id), 64'h0);
    chk("t1_data", 64'(bus.data_out_i_in), 64'h00_02_800001);
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    #1 chk("t1_empty", 64'(bus.pndng_i_in), 64'h0);

    // All four valid, popin held: 0,1,2,3,0 back-to-back.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(i, mk(8'h10 + 8'(i), 4'(i), 4'(i), 1'b0, 23'h100 + 23'(i)));
      push_exp(mk(8'h00, 4'(i), 4'(i), 1'b0, 23'h100 + 23'(i)), 2'(i));
    end
    push_exp(mk(8'h00, 4'd5, 4'd5, 1'b1, 23'h7ABCD), 2'd0);
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
    tick();
    chk("t2_first", 64'(bus.pndng_i_in), 64'h1);
    set_req(0, mk(8'h55, 4'd5, 4'd5, 1'b1, 23'h7ABCD));
    bus.popin = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      #1;
      chk("t2_pndng", 64'(bus.pndng_i_in), 64'h1);
      chk("t2_order", 64'(bus.gnt_id), 64'(order[k]));
    end
    tick();
    bus.popin = 1'b0;
    #1 chk("t2_empty", 64'(bus.pndng_i_in), 64'h0);

    // Illegal destinations: row F, then boundary col 6 and row 6. rr_ptr is 1 here.
    set_req(2, mk(8'h33, 4'hF, 4'd1, 1'b0, 23'd2));
    drop_q.push_back(16'd1);
    tick();
    #1;
    chk("t3_drop_pulse", 64'(bus.drop_pulse), 64'h1);
    chk("t3_drop_cnt", 64'(bus.drop_cnt), 64'd1);
    chk("t3_no_load", 64'(bus.pndng_i_in), 64'h0);
    set_req(0, mk(8'h01, 4'd1, 4'd1, 1'b0, 23'h11));
    set_req(3, mk(8'h03, 4'd3, 4'd3, 1'b1, 23'h33));
    push_exp(mk(8'h00, 4'd3, 4'd3, 1'b1, 23'h33), 2'd3);
    push_exp(mk(8'h00, 4'd1, 4'd1, 1'b0, 23'h11), 2'd0);
    tick();
    #1 chk("t3_pulse_once", 64'(bus.drop_pulse), 64'h0);
    chk("t3_gnt3_first", 64'(bus.gnt_id), 64'd3);
    bus.popin = 1'b1;
    tick();
    tick();
    bus.popin = 1'b0;
    set_req(1, mk(8'h44, 4'd0, 4'd6, 1'b0, 23'd4));
    drop_q.push_back(16'd2);
    tick();
    #1 chk("t3_col6_drop", 64'(bus.drop_cnt), 64'd2);
    set_req(1, mk(8'h45, 4'd6, 4'd0, 1'b0, 23'd5));
    drop_q.push_back(16'd3);
    tick();
    #1;
    chk("t3_row6_drop", 64'(bus.drop_cnt), 64'd3);
    chk("t3_still_empty", 64'(bus.pndng_i_in), 64'h0);

    // Stall: FULL with popin low for 10 cycles, then release; rr_ptr is 2 here.
    set_req(0, mk(8'hC0, 4'd2, 4'd3, 1'b0, 23'h0C0C0));
    held = mk(8'h00, 4'd2, 4'd3, 1'b0, 23'h0C0C0);
    push_exp(held, 2'd0);
    push_exp(mk(8'h00, 4'd1, 4'd4, 1'b1, 23'd1), 2'd1);
    push_exp(mk(8'h00, 4'd3, 4'd0, 1'b0, 23'd3), 2'd3);
    tick();
    set_req(1, mk(8'hC1, 4'd1, 4'd4, 1'b1, 23'd1));
    set_req(3, mk(8'hC3, 4'd3, 4'd0, 1'b0, 23'd3));
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_stall_ready", 64'(bus.req_ready), 64'h0);
      chk("t4_stall_data", 64'(bus.data_out_i_in), 64'(held));
      tick();
    end
    bus.popin = 1'b1;
    #1 chk("t4_pop_ready", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.popin = 1'b0;
    #1;
    chk("t4_gnt1", 64'(bus.gnt_id), 64'd1);
    chk("t4_full", 64'(bus.pndng_i_in), 64'h1);
    bus.popin = 1'b1;
    tick();
    tick();
    bus.popin = 1'b0;

    // popin while EMPTY: sticky error, nothing else moves.
    #1 chk("t5_err_before", 64'(bus.err_pop), 64'h0);
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    #1;
    chk("t5_err_set", 64'(bus.err_pop), 64'h1);
    chk("t5_pndng", 64'(bus.pndng_i_in), 64'h0);
    chk("t5_drop_cnt", 64'(bus.drop_cnt), 64'd3);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(bus.err_pop), 64'h1);

    // Async reset mid-cycle while FULL; then en gating.
    set_req(0, mk(8'hE0, 4'd1, 4'd2, 1'b0, 23'd5));
    tick();
    #1 chk("t6_full", 64'(bus.pndng_i_in), 64'h1);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_async_pndng", 64'(bus.pndng_i_in), 64'h0);
    chk("t6_async_data", 64'(bus.data_out_i_in), 64'h0);
    chk("t6_async_err", 64'(bus.err_pop), 64'h0);
    chk("t6_async_drop", 64'(bus.drop_cnt), 64'h0);
    bus.en = 1'b0;
    set_req(0, mk(8'hE1, 4'd0, 4'd0, 1'b1, 23'd6));
    @(posedge clk);
    #1 reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_en0_ready", 64'(bus.req_ready), 64'h0);
      chk("t6_en0_pndng", 64'(bus.pndng_i_in), 64'h0);
      tick();
    end
    bus.en = 1'b1;
    #1 chk("t6_en1_ready", 64'(bus.req_ready), 64'h1);
    push_exp(mk(8'h00, 4'd0, 4'd0, 1'b1, 23'd6), 2'd0);
    tick();
    bus.en = 1'b0;
    set_req(1, mk(8'hE2, 4'd3, 4'd3, 1'b0, 23'd7));
    push_exp(mk(8'h00, 4'd3, 4'd3, 1'b0, 23'd7), 2'd1);
    bus.popin = 1'b1;
    #1 chk("t6_drain_ready", 64'(bus.req_ready), 64'h0);
    tick();
    bus.popin = 1'b0;
    #1 chk("t6_drained", 64'(bus.pndng_i_in), 64'h0);
    bus.en = 1'b1;
    #1 chk("t6_regrant", 64'(bus.req_ready), 64'b0010);
    tick();
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    #1 chk("t6_final_empty", 64'(bus.pndng_i_in), 64'h0);

    repeat (2) tick();
    chk("sb_pops_left", 64'(exp_q.size()), 64'd0);
    chk("sb_drops_left", 64'(drop_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
